modulo_varredura_matriz: RTL and testbench

Column-scan driver for the 5x7 LED matrix. It consumes the 2-bit pattern select sel_m produced by the state-to-select decoder and turns it into multiplexed column/row drive.
- Internal prescaler sets the column dwell time.
- Select is sampled only at frame boundaries, so a pattern change never tears mid-frame.
- Sits between the control FSM/select decoder and the matrix pins.

---
 rtl/modulo_varredura_matriz.sv | 148 ++++++++++++++
 tb/tb_modulo_varredura_matriz.sv | 136 +++++++++++++
 2 files changed

// File: rtl/modulo_varredura_matriz.sv
// modulo_varredura_matriz
// Column-scan driver for a 5x7 LED matrix. A prescaler sets the column
// dwell time; the pattern select is latched only at frame wrap so a
// pattern change never tears mid-frame. Outputs are registered.
// Optional build macro: SAIDA_ATIVA_BAIXA_EN inverts col/lin (active-low
// drive for common-anode/sinking drivers); fim_quadro is never inverted.
module modulo_varredura_matriz #(
    parameter int N_COL = 5,
    parameter int N_LIN = 7,
    parameter int DIV   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel_m,
    output logic [N_COL-1:0] col,
    output logic [N_LIN-1:0] lin,
    output logic             fim_quadro
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N_COL > 1) ? $clog2(N_COL) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_COL - 1);

`ifdef SAIDA_ATIVA_BAIXA_EN
    localparam logic [N_COL-1:0] COL_IDLE = '1;
    localparam logic [N_LIN-1:0] LIN_IDLE = '1;
`else
    localparam logic [N_COL-1:0] COL_IDLE = '0;
    localparam logic [N_LIN-1:0] LIN_IDLE = '0;
`endif

    logic [PW-1:0]    presc_q, presc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       sel_lat_q, sel_lat_d;
    logic [N_COL-1:0] col_q, col_d;
    logic [N_LIN-1:0] lin_q, lin_d;
    logic             fim_quadro_q, fim_quadro_d;

    logic tick;
    logic wrap;

    // 7-row glyph for one column of the selected pattern (bit 0 = top row)
    function automatic logic [6:0] rom_col(input logic [1:0] sel, input logic [IW-1:0] idx);
        logic [6:0] v;
        v = '0;
        unique case (sel)
            2'b00: v = 7'h00;
            2'b01: begin
                if (idx == IW'(0) || idx == IW'(4))      v = 7'h41;
                else if (idx == IW'(1) || idx == IW'(3)) v = 7'h22;
                else if (idx == IW'(2))                  v = 7'h1C;
                else                                     v = 7'h00;
            end
            2'b10: begin
                if (idx == IW'(0) || idx == IW'(4))      v = 7'h7F;
                else if (idx == IW'(1) || idx == IW'(2) || idx == IW'(3))
                                                         v = 7'h41;
                else                                     v = 7'h00;
            end
            2'b11: begin
                if (idx <= IW'(4))                       v = 7'h7F;
                else                                     v = 7'h00;
            end
            default: v = 7'h00;
        endcase
        return v;
    endfunction

    // Dwell tick and frame wrap strobes
    always_comb begin
        tick = en && (presc_q == PRESC_LAST);
        wrap = tick && (idx_q == IDX_LAST);
    end

    // Scan state: prescaler, column index, frame-latched select
    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        sel_lat_d = sel_lat_q;
        if (en) begin
            if (tick) begin
                presc_d = '0;
                if (wrap) begin
                    idx_d     = '0;
                    sel_lat_d = sel_m;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Output drive computed from current state (1-cycle registered latency)
    always_comb begin
        logic [N_COL-1:0] col_raw;
        logic [N_LIN-1:0] lin_raw;
        logic [6:0]       glyph;
        col_raw      = '0;
        lin_raw      = '0;
        glyph        = rom_col(sel_lat_q, idx_q);
        col_d        = COL_IDLE;
        lin_d        = LIN_IDLE;
        fim_quadro_d = 1'b0;
        if (en) begin
            col_raw = N_COL'(1) << idx_q;
            for (int unsigned b = 0; b < N_LIN; b++) begin
                if (b < 7) lin_raw[b] = glyph[b];
            end
`ifdef SAIDA_ATIVA_BAIXA_EN
            col_d = ~col_raw;
            lin_d = ~lin_raw;
`else
            col_d = col_raw;
            lin_d = lin_raw;
`endif
            fim_quadro_d = wrap;
        end
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            sel_lat_q    <= 2'b00;
            col_q        <= COL_IDLE;
            lin_q        <= LIN_IDLE;
            fim_quadro_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            sel_lat_q    <= sel_lat_d;
            col_q        <= col_d;
            lin_q        <= lin_d;
            fim_quadro_q <= fim_quadro_d;
        end
    end

    assign col        = col_q;
    assign lin        = lin_q;
    assign fim_quadro = fim_quadro_q;

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Testbench for modulo_varredura_matriz (DIV=4). Reference model tracks a
// single position counter within the frame and a latched select.
module tb_modulo_varredura_matriz;

    localparam int N_COL = 5;
    localparam int N_LIN = 7;
    localparam int DIV   = 4;
    localparam int FRAME = N_COL * DIV;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       sel_m;
    logic [N_COL-1:0] col;
    logic [N_LIN-1:0] lin;
    logic             fim_quadro;

    modulo_varredura_matriz #(.N_COL(N_COL), .N_LIN(N_LIN), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sel_m      (sel_m),
        .col        (col),
        .lin        (lin),
        .fim_quadro (fim_quadro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int rom [4][5] = '{
        '{'h00, 'h00, 'h00, 'h00, 'h00},
        '{'h41, 'h22, 'h1C, 'h22, 'h41},
        '{'h7F, 'h41, 'h41, 'h41, 'h7F},
        '{'h7F, 'h7F, 'h7F, 'h7F, 'h7F}
    };

    int pos;
    int sel_mod;
    int total;
    int passed;
    int fim_seen;

    logic [N_COL-1:0] exp_col;
    logic [N_LIN-1:0] exp_lin;
    logic             exp_fim;

    task automatic check_outputs();
        total++;
        assert (col === exp_col) begin passed++; end
        else $error("FAIL col: got %b expected %b (t=%0t)", col, exp_col, $time);
        total++;
        assert (lin === exp_lin) begin passed++; end
        else $error("FAIL lin: got %h expected %h (t=%0t)", lin, exp_lin, $time);
        total++;
        assert (fim_quadro === exp_fim) begin passed++; end
        else $error("FAIL fim_quadro: got %b expected %b (t=%0t)", fim_quadro, exp_fim, $time);
    endtask

    // One clock with the given inputs; model advances on the edge, outputs checked 1 time unit later
    task automatic step(input logic r, input logic e, input logic [1:0] s);
        logic [N_COL-1:0] c;
        logic [N_LIN-1:0] l;
        rst   = r;
        en    = e;
        sel_m = s;
        @(posedge clk);
        c = '0;
        l = '0;
        exp_fim = 1'b0;
        if (r) begin
            pos     = 0;
            sel_mod = 0;
        end else if (e) begin
            c = N_COL'(1) << (pos / DIV);
            l = N_LIN'(rom[sel_mod][pos / DIV]);
            exp_fim = (pos == FRAME - 1);
            if (exp_fim) sel_mod = int'(s);
            pos = (pos + 1) % FRAME;
        end
`ifdef SAIDA_ATIVA_BAIXA_EN
        exp_col = ~c;
        exp_lin = ~l;
`else
        exp_col = c;
        exp_lin = l;
`endif
        #1;
        check_outputs();
        if (fim_quadro === 1'b1) fim_seen++;
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        pos      = 0;
        sel_mod  = 0;
        fim_seen = 0;
        rst      = 1'b1;
        en       = 1'b1;
        sel_m    = 2'b10;

        // Reset held two cycles with sel_m=10
        step(1'b1, 1'b1, 2'b10);
        step(1'b1, 1'b1, 2'b10);
        // Blank first frame, then border frame
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 2'b10);
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 2'b10);
        // Border frame with select changed to X during column 2
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'b01);
        // X frame, en dropped 2 cycles into column 3 for 6 cycles
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 6; i++)  step(1'b0, 1'b0, 2'b01);
        for (int i = 0; i < 6; i++)  step(1'b0, 1'b1, 2'b11);
        // Lamp test frame, then X frames with a reset in column 2
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 10; i++)    step(1'b0, 1'b1, 2'b01);
        step(1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b1, 2'b01);

        // Frame pulse count over the directed phase
        total++;
        assert (fim_seen == 7) begin passed++; end
        else $error("FAIL fim_count: got %0d expected %0d", fim_seen, 7);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 97) == 0, ($urandom % 6) != 0, 2'($urandom % 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
